// File: rtl/modexp_operand_sequencer.sv
// Loads message/exponent/modulus words, runs the modexp core with a timeout, then emits one result word.
// Latency: core_start 2 cycles after the modulus word; never stalls rx, holds the result while tx_busy is high.
module modexp_operand_sequencer #(
    parameter int N         = 32,
    parameter int TIMEOUT_W = 24
) (
    input  logic           iCE_CLK,
    input  logic           rst,
    input  logic           rx_valid,
    input  logic [N-1:0]   rx_bytes,
    output logic           core_start,
    output logic [N-1:0]   core_msg,
    output logic [N-1:0]   core_exp,
    output logic [N-1:0]   core_mod,
    input  logic           core_done,
    input  logic [N-1:0]   core_result,
    input  logic           tx_busy,
    output logic [N-1:0]   tx_bytes,
    output logic           tx_valid,
    output logic           overrun,
    output logic           timeout,
    output logic [2:0]     state_dbg
);

    typedef enum logic [2:0] {
        LD_MSG = 3'd0,
        LD_EXP = 3'd1,
        LD_MOD = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        SEND   = 3'd5
    } state_t;

    state_t               state;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;

    // Timeout fires on the cycle the counter would reach all-ones.
    always_comb begin
        cnt_inc = wait_cnt + 1'b1;
    end

    assign state_dbg = state;

    always_ff @(posedge iCE_CLK) begin
        if (rst) begin
            state      <= LD_MSG;
            core_msg   <= '0;
            core_exp   <= '0;
            core_mod   <= '0;
            tx_bytes   <= '0;
            core_start <= 1'b0;
            tx_valid   <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            core_start <= 1'b0;
            tx_valid   <= 1'b0;
            if (rx_valid && (state == START || state == WAIT || state == SEND))
                overrun <= 1'b1;
            case (state)
                LD_MSG: if (rx_valid) begin
                    core_msg <= rx_bytes;
                    state    <= LD_EXP;
                end
                LD_EXP: if (rx_valid) begin
                    core_exp <= rx_bytes;
                    state    <= LD_MOD;
                end
                LD_MOD: if (rx_valid) begin
                    core_mod <= rx_bytes;
                    state    <= START;
                end
                START: begin
                    core_start <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // core_done takes priority over a coincident saturation.
                    if (core_done) begin
                        tx_bytes <= core_result;
                        timeout  <= 1'b0;
                        state    <= SEND;
                    end else if (&cnt_inc) begin
                        wait_cnt <= cnt_inc;
                        tx_bytes <= {N{1'b1}};
                        timeout  <= 1'b1;
                        state    <= SEND;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                SEND: if (!tx_busy) begin
                    tx_valid <= 1'b1;
                    state    <= LD_MSG;
                end
                default: state <= LD_MSG;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_operand_sequencer.sv
// Scoreboard bench for modexp_operand_sequencer with a short timeout counter.
module tb_modexp_operand_sequencer;

    localparam int N = 32;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [N-1:0]  rx_bytes;
    logic          core_start;
    logic [N-1:0]  core_msg;
    logic [N-1:0]  core_exp;
    logic [N-1:0]  core_mod;
    logic          core_done;
    logic [N-1:0]  core_result;
    logic          tx_busy;
    logic [N-1:0]  tx_bytes;
    logic          tx_valid;
    logic          overrun;
    logic          timeout;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    int tx_pulses = 0;
    logic [N-1:0] exp_q[$];

    modexp_operand_sequencer #(.N(N), .TIMEOUT_W(TW)) dut (
        .iCE_CLK     (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_bytes    (rx_bytes),
        .core_start  (core_start),
        .core_msg    (core_msg),
        .core_exp    (core_exp),
        .core_mod    (core_mod),
        .core_done   (core_done),
        .core_result (core_result),
        .tx_busy     (tx_busy),
        .tx_bytes    (tx_bytes),
        .tx_valid    (tx_valid),
        .overrun     (overrun),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Every tx_valid pulse pops the next expected result word.
    always @(negedge clk) begin
        if (tx_valid) begin
            logic [N-1:0] want;
            tx_pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got=%h expected none", tx_bytes);
            end else begin
                want = exp_q.pop_front();
                if (tx_bytes !== want) begin
                    errors++;
                    $display("FAIL tx_word got=%h expected=%h", tx_bytes, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] w);
        rx_valid = 1'b1;
        rx_bytes = w;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic load3(input logic [N-1:0] m, input logic [N-1:0] e, input logic [N-1:0] md);
        send_word(m);
        send_word(e);
        send_word(md);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (state_dbg !== 3'd0 || core_msg !== '0 || core_exp !== '0 || core_mod !== '0 ||
            tx_bytes !== '0 || core_start !== 1'b0 || tx_valid !== 1'b0 ||
            overrun !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got st=%0d msg=%h exp=%h mod=%h tx=%h cs=%b tv=%b ov=%b to=%b expected all zero",
                     state_dbg, core_msg, core_exp, core_mod, tx_bytes, core_start, tx_valid, overrun, timeout);
        end
    endtask

    task automatic test_normal();
        int p0;
        load3(32'h4, 32'hD, 32'h1F1);
        checks++;
        if (core_msg !== 32'd4 || core_exp !== 32'd13 || core_mod !== 32'd497) begin
            errors++;
            $display("FAIL operands got %0d %0d %0d expected 4 13 497", core_msg, core_exp, core_mod);
        end
        checks++;
        if (core_start !== 1'b0 || state_dbg !== 3'd3) begin
            errors++;
            $display("FAIL start_early got cs=%b st=%0d expected cs=0 st=3", core_start, state_dbg);
        end
        tick();
        checks++;
        if (core_start !== 1'b1 || state_dbg !== 3'd4) begin
            errors++;
            $display("FAIL start_pulse got cs=%b st=%0d expected cs=1 st=4", core_start, state_dbg);
        end
        tick();
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL start_width got cs=%b expected 0", core_start);
        end
        tick();
        core_done = 1'b1;
        core_result = 32'h1BD;
        exp_q.push_back(32'h1BD);
        p0 = tx_pulses;
        tick();
        core_done = 1'b0;
        checks++;
        if (state_dbg !== 3'd5 || tx_bytes !== 32'h1BD) begin
            errors++;
            $display("FAIL normal_send got st=%0d tx=%h expected st=5 tx=000001bd", state_dbg, tx_bytes);
        end
        tick();
        tick();
        checks++;
        if (tx_pulses !== p0 + 1 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL normal_done got pulses=%0d st=%0d expected pulses=%0d st=0", tx_pulses, state_dbg, p0 + 1);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        logic saw_valid;
        logic moved;
        load3(32'h11, 32'h22, 32'h33);
        tick();
        tx_busy = 1'b1;
        core_done = 1'b1;
        core_result = 32'hCAFE0001;
        exp_q.push_back(32'hCAFE0001);
        p0 = tx_pulses;
        tick();
        core_done = 1'b0;
        saw_valid = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_valid !== 1'b0) saw_valid = 1'b1;
            if (tx_bytes !== 32'hCAFE0001 || state_dbg !== 3'd5) moved = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || moved !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got valid_seen=%b changed=%b expected 0 0", saw_valid, moved);
        end
        tx_busy = 1'b0;
        tick();
        tick();
        checks++;
        if (tx_pulses !== p0 + 1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got pulses=%0d tv=%b expected pulses=%0d tv=0", tx_pulses, tx_valid, p0 + 1);
        end
    endtask

    task automatic test_timeout();
        load3(32'h1, 32'h2, 32'h3);
        tick();
        exp_q.push_back(32'hFFFFFFFF);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (state_dbg !== 3'd4 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_early got st=%0d to=%b expected st=4 to=0", state_dbg, timeout);
        end
        tick();
        checks++;
        if (state_dbg !== 3'd5 || timeout !== 1'b1 || tx_bytes !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL to_fire got st=%0d to=%b tx=%h expected st=5 to=1 tx=ffffffff", state_dbg, timeout, tx_bytes);
        end
        tick();
        tick();
        checks++;
        if (timeout !== 1'b1 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL to_sticky got to=%b st=%0d expected to=1 st=0", timeout, state_dbg);
        end
        load3(32'h7, 32'h8, 32'h9);
        tick();
        tick();
        core_done = 1'b1;
        core_result = 32'h00000042;
        exp_q.push_back(32'h00000042);
        tick();
        core_done = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got to=%b expected 0", timeout);
        end
        tick();
        tick();
    endtask

    task automatic test_overrun();
        load3(32'h5, 32'h6, 32'h7);
        tick();
        tick();
        send_word(32'hDEADBEEF);
        checks++;
        if (overrun !== 1'b1 || state_dbg !== 3'd4 || core_msg !== 32'h5 || core_exp !== 32'h6 || core_mod !== 32'h7) begin
            errors++;
            $display("FAIL ov_set got ov=%b st=%0d ops=%h %h %h expected ov=1 st=4 ops=5 6 7",
                     overrun, state_dbg, core_msg, core_exp, core_mod);
        end
        core_done = 1'b1;
        core_result = 32'h0000BEEF;
        exp_q.push_back(32'h0000BEEF);
        tick();
        core_done = 1'b0;
        tick();
        tick();
        checks++;
        if (overrun !== 1'b1 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL ov_sticky got ov=%b st=%0d expected ov=1 st=0", overrun, state_dbg);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        load3(32'hA, 32'hB, 32'hC);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (state_dbg !== 3'd0 || core_msg !== '0 || core_exp !== '0 || core_mod !== '0 ||
            tx_bytes !== '0 || overrun !== 1'b0 || timeout !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got st=%0d ops=%h %h %h tx=%h ov=%b to=%b expected all zero",
                     state_dbg, core_msg, core_exp, core_mod, tx_bytes, overrun, timeout);
        end
        p0 = tx_pulses;
        core_done = 1'b1;
        core_result = 32'h99999999;
        tick();
        core_done = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (tx_pulses !== p0 || state_dbg !== 3'd0 || tx_bytes !== '0) begin
            errors++;
            $display("FAIL late_done got pulses=%0d st=%0d tx=%h expected pulses=%0d st=0 tx=0",
                     tx_pulses, state_dbg, tx_bytes, p0);
        end
    endtask

    task automatic test_simultaneous();
        load3(32'h1, 32'h1, 32'h1);
        tick();
        for (int i = 0; i < 14; i++) tick();
        core_done = 1'b1;
        core_result = 32'h12345678;
        exp_q.push_back(32'h12345678);
        tick();
        core_done = 1'b0;
        checks++;
        if (state_dbg !== 3'd5 || timeout !== 1'b0 || tx_bytes !== 32'h12345678) begin
            errors++;
            $display("FAIL sat_done got st=%0d to=%b tx=%h expected st=5 to=0 tx=12345678", state_dbg, timeout, tx_bytes);
        end
        tick();
        tick();
        load3(32'h2, 32'h3, 32'h4);
        tick();
        tick();
        rx_valid = 1'b1;
        rx_bytes = 32'hDEADBEEF;
        core_done = 1'b1;
        core_result = 32'h0000ABCD;
        exp_q.push_back(32'h0000ABCD);
        tick();
        rx_valid = 1'b0;
        core_done = 1'b0;
        checks++;
        if (overrun !== 1'b1 || state_dbg !== 3'd5 || tx_bytes !== 32'h0000ABCD || core_msg !== 32'h2) begin
            errors++;
            $display("FAIL rx_done got ov=%b st=%0d tx=%h msg=%h expected ov=1 st=5 tx=0000abcd msg=2",
                     overrun, state_dbg, tx_bytes, core_msg);
        end
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_bytes = '0;
        core_done = 1'b0;
        core_result = '0;
        tx_busy = 1'b0;
        test_reset();
        test_normal();
        test_backpressure();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_simultaneous();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modexp_operand_sequencer.md
Name: modexp_operand_sequencer

Overview:
- Sits between serial_to_parallel (upstream) and parallel_to_serial (downstream) in the UART RSA datapath.
- Collects three consecutive N-bit words from the UART word assembler: message, exponent, modulus.
- Launches the modular-exponentiation core, waits for its result (with timeout), then hands one N-bit result word to the word serializer.

Parameters:
- N, 32, operand/result word width in bits.
- TIMEOUT_W, 24, width of the core-wait counter; timeout fires after 2^TIMEOUT_W - 1 cycles in WAIT.

Ports:
- iCE_CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_valid  in  1  one-cycle pulse from serial_to_parallel: rx_bytes holds a complete word.
- rx_bytes  in  N  incoming word.
- core_start  out  1  one-cycle start pulse to the modexp core.
- core_msg  out  N  latched message operand.
- core_exp  out  N  latched exponent operand.
- core_mod  out  N  latched modulus operand.
- core_done  in  1  one-cycle pulse from the core: core_result valid.
- core_result  in  N  core result word.
- tx_busy  in  1  high while parallel_to_serial is still shifting out a previous word.
- tx_bytes  out  N  result word to parallel_to_serial.
- tx_valid  out  1  one-cycle pulse: tx_bytes valid.
- overrun  out  1  sticky: a word arrived while not in a LOAD state.
- timeout  out  1  sticky: the last core run timed out.
- state_dbg  out  3  current state encoding, for LEDs.

Behaviour:
- Reset (rst high at an edge, from any state, including mid-run):
  - state = LD_MSG; core_msg/exp/mod = 0; tx_bytes = 0.
  - core_start, tx_valid, overrun, timeout = 0; wait counter = 0.
- State encoding: LD_MSG=0, LD_EXP=1, LD_MOD=2, START=3, WAIT=4, SEND=5. state_dbg reflects the registered state.
- LD_MSG: on rx_valid, core_msg <= rx_bytes, go to LD_EXP.
- LD_EXP: on rx_valid, core_exp <= rx_bytes, go to LD_MOD.
- LD_MOD: on rx_valid, core_mod <= rx_bytes, go to START.
- START: assert core_start for exactly one cycle, clear the wait counter, go to WAIT.
  - core_start is registered: it is high in the cycle after entering START.
  - Latency from the modulus rx_valid edge to core_start high is 2 cycles.
- WAIT: counter increments each cycle.
  - core_done: latch core_result into tx_bytes, clear timeout, go to SEND.
  - Counter reaching all-ones without core_done: tx_bytes <= {N{1'b1}}, timeout <= 1, go to SEND.
  - core_done on the same cycle as counter saturation: core_done wins; the result is used and timeout stays 0.
- SEND: while tx_busy = 1, hold. First cycle with tx_busy = 0: pulse tx_valid for one cycle, go to LD_MSG.
  - tx_bytes is stable from SEND entry until the next WAIT exit.
- Operands core_msg/exp/mod hold their values from load until overwritten by the next load or reset; they stay stable throughout WAIT.
- rx_valid in START, WAIT or SEND: the word is dropped, overrun <= 1 (sticky until rst), state unchanged.
- core_done outside WAIT: ignored; no state or flag change.
- rx_valid and core_done in the same cycle in WAIT: core_done is handled and overrun is set.
- No back-pressure toward serial_to_parallel; its pulses are never stalled.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset then normal run, N=32: words 0x00000004, 0x0000000D, 0x000001F1 → core_msg=4, core_exp=13, core_mod=497; one core_start pulse 2 cycles after the third rx_valid; core_done with result 0x000001BD → tx_bytes=0x000001BD, tx_valid pulses once, state_dbg returns to 0.
- Back-pressure: tx_busy held high for 50 cycles when SEND is entered → tx_valid stays 0 throughout; it pulses exactly once on the first cycle after tx_busy falls; tx_bytes unchanged.
- Timeout, with TIMEOUT_W=4: load three words and never assert core_done → 15 cycles after WAIT entry, tx_bytes=0xFFFFFFFF, timeout=1, then tx_valid pulses; the next successful run clears timeout to 0.
- Overrun: extra rx_valid (0xDEADBEEF) during WAIT → overrun=1, core_msg/exp/mod unchanged, result flow unaffected; overrun still 1 after the run until rst.
- Reset mid-operation: assert rst in WAIT after loading operands → all outputs 0, state_dbg=0; a late core_done after reset is ignored and produces no tx_valid.
- Simultaneous events: core_done on the counter-saturation cycle → result word sent, timeout=0; rx_valid coincident with core_done → overrun=1, result still sent.
